// File: rtl/tuner_pkg.sv
// Shared constants for the tuner note display: note codes, tune status
// encoding, FSM states and active-low 7-segment glyphs (bit order g..a).
package tuner_pkg;

  typedef logic [6:0] seg_t;

  // Note codes, strings low to high; anything above NOTE_MAX means no note
  localparam logic [3:0] NOTE_E_LOW  = 4'd0;
  localparam logic [3:0] NOTE_A      = 4'd1;
  localparam logic [3:0] NOTE_D      = 4'd2;
  localparam logic [3:0] NOTE_G      = 4'd3;
  localparam logic [3:0] NOTE_B      = 4'd4;
  localparam logic [3:0] NOTE_E_HIGH = 4'd5;
  localparam logic [3:0] NOTE_MAX    = 4'd5;
  localparam logic [3:0] NOTE_NONE   = 4'hF;

  typedef enum logic [1:0] {
    TUNE_OK    = 2'b00,
    TUNE_FLAT  = 2'b01,
    TUNE_SHARP = 2'b10,
    TUNE_NOSIG = 2'b11
  } tune_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_e;

  // Note letter glyphs
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_G = 7'b0000010;
  localparam seg_t SEG_B = 7'b0000011;

  // Tune direction glyphs
  localparam seg_t SEG_FLAT  = 7'b1000111;
  localparam seg_t SEG_SHARP = 7'b0001001;

  // String number glyphs
  localparam seg_t SEG_NUM_1 = 7'b1111001;
  localparam seg_t SEG_NUM_2 = 7'b0100100;
  localparam seg_t SEG_NUM_3 = 7'b0110000;
  localparam seg_t SEG_NUM_4 = 7'b0011001;
  localparam seg_t SEG_NUM_5 = 7'b0010010;
  localparam seg_t SEG_NUM_6 = 7'b0000010;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/note_glyph_rom.sv
// Combinational lookup: note code -> note letter glyph and string number glyph.
// Codes outside 0..5 give a dash for the letter and blank for the number.
module note_glyph_rom
  import tuner_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       note_glyph_c,
  output seg_t       string_glyph_c
);

  // Decode note code into both glyphs
  always_comb begin
    note_glyph_c   = SEG_DASH;
    string_glyph_c = SEG_BLANK;
    case (code)
      NOTE_E_LOW:  begin note_glyph_c = SEG_E; string_glyph_c = SEG_NUM_6; end
      NOTE_A:      begin note_glyph_c = SEG_A; string_glyph_c = SEG_NUM_5; end
      NOTE_D:      begin note_glyph_c = SEG_D; string_glyph_c = SEG_NUM_4; end
      NOTE_G:      begin note_glyph_c = SEG_G; string_glyph_c = SEG_NUM_3; end
      NOTE_B:      begin note_glyph_c = SEG_B; string_glyph_c = SEG_NUM_2; end
      NOTE_E_HIGH: begin note_glyph_c = SEG_E; string_glyph_c = SEG_NUM_1; end
      default:     begin note_glyph_c = SEG_DASH; string_glyph_c = SEG_BLANK; end
    endcase
  end

endmodule

// File: rtl/note_display_ctrl.sv
// Tuner note display controller: debounces incoming note samples, commits a
// note after STABLE_COUNT matching samples and drives registered 7-segment
// digits. Optional macro NOTE_BLINK_EN blinks the note digit while locked
// and out of tune.
module note_display_ctrl
  import tuner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned BLINK_HALF   = 12_500_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    note_valid,
  input  logic [3:0]              note_code,
  input  logic [1:0]              tune_err,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [3:0]              shown_code,
  output logic                    locked
);

  localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);
  localparam int unsigned HEX_W = 7 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_COUNT);
  localparam logic [HEX_W-1:0] HEX_RESET = {{(HEX_W-7){1'b1}}, SEG_DASH};

  // Elaboration-time parameter sanity checks
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS out of range 2..8");
  end
  if (STABLE_COUNT < 1 || STABLE_COUNT > 255) begin : g_bad_stable
    $error("STABLE_COUNT out of range 1..255");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink
    $error("BLINK_HALF must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       shown_q, shown_d;
  tune_e            tune_q, tune_d;
  logic             locked_q;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic             sample_ok;
  logic             blink_hide_c;
  seg_t             rom_note_c, rom_string_c, digit1_c;

  // State register and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      cand_q   <= NOTE_NONE;
      shown_q  <= NOTE_NONE;
      tune_q   <= TUNE_OK;
      locked_q <= 1'b0;
      hex_q    <= HEX_RESET;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cand_q   <= cand_d;
      shown_q  <= shown_d;
      tune_q   <= tune_d;
      locked_q <= (state_d == S_LOCKED);
      hex_q    <= hex_d;
    end
  end

  // Next-state: filtering, acquisition and commit
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cand_d    = cand_q;
    shown_d   = shown_q;
    tune_d    = tune_q;
    sample_ok = (note_code <= NOTE_MAX) && (tune_err != 2'(TUNE_NOSIG));
    if (note_valid) begin
      if (!sample_ok) begin
        state_d = S_IDLE;
        count_d = '0;
        cand_d  = NOTE_NONE;
        shown_d = NOTE_NONE;
      end else begin
        tune_d = tune_e'(tune_err);
        case (state_q)
          S_IDLE: begin
            state_d = S_ACQUIRE;
            cand_d  = note_code;
            count_d = CNT_W'(1);
          end
          S_ACQUIRE: begin
            if (note_code == cand_q) begin
              if (count_q < CNT_MAX) count_d = CNT_W'(count_q + 1'b1);
            end else begin
              cand_d  = note_code;
              count_d = CNT_W'(1);
            end
          end
          S_LOCKED: begin
            if (note_code != shown_q) begin
              state_d = S_ACQUIRE;
              cand_d  = note_code;
              count_d = CNT_W'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
        // Commit on the same edge the count reaches the threshold
        if (state_d == S_ACQUIRE && count_d >= CNT_MAX) begin
          state_d = S_LOCKED;
          shown_d = cand_d;
        end
      end
    end
  end

`ifdef NOTE_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_hidden_q, blink_hidden_d;
  logic               commit_c;

  assign commit_c = (state_d == S_LOCKED) &&
                    ((state_q != S_LOCKED) || (shown_d != shown_q));

  // Blink counter and phase registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_q    <= '0;
      blink_hidden_q <= 1'b0;
    end else begin
      blink_cnt_q    <= blink_cnt_d;
      blink_hidden_q <= blink_hidden_d;
    end
  end

  // Free-running half-period counter, restarted visible on each commit
  always_comb begin
    blink_cnt_d    = BLINK_W'(blink_cnt_q + 1'b1);
    blink_hidden_d = blink_hidden_q;
    if (commit_c) begin
      blink_cnt_d    = '0;
      blink_hidden_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d    = '0;
      blink_hidden_d = ~blink_hidden_q;
    end
  end

  assign blink_hide_c = (state_d == S_LOCKED) && (tune_d != TUNE_OK) && blink_hidden_d;
`else
  assign blink_hide_c = 1'b0;
`endif

  note_glyph_rom u_rom (
    .code           (shown_d),
    .note_glyph_c   (rom_note_c),
    .string_glyph_c (rom_string_c)
  );

  // Digit assembly from next-cycle state so the display tracks the commit edge
  always_comb begin
    digit1_c = SEG_BLANK;
    if (shown_d != NOTE_NONE) begin
      if (tune_d == TUNE_FLAT)       digit1_c = SEG_FLAT;
      else if (tune_d == TUNE_SHARP) digit1_c = SEG_SHARP;
    end
    hex_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i == 0)      hex_d[7*i +: 7] = blink_hide_c ? SEG_BLANK : rom_note_c;
      else if (i == 1) hex_d[7*i +: 7] = digit1_c;
      else if (i == 2) hex_d[7*i +: 7] = rom_string_c;
    end
  end

  assign hex_out    = hex_q;
  assign shown_code = shown_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_note_display_ctrl.sv
// Directed self-checking bench for note_display_ctrl (3 digits, STABLE_COUNT=4,
// BLINK_HALF=4). Blink checks are compiled in only with NOTE_BLINK_EN.
module tb_note_display_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        note_valid = 1'b0;
  logic [3:0]  note_code = 4'hF;
  logic [1:0]  tune_err = 2'b00;
  logic [20:0] hex_out;
  logic [3:0]  shown_code;
  logic        locked;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G_E = 7'b0000110, G_A = 7'b0001000, G_D = 7'b0100001;
  localparam logic [6:0] G_G = 7'b0000010, G_DASH = 7'b0111111, G_BLANK = 7'b1111111;
  localparam logic [6:0] G_L = 7'b1000111, G_H = 7'b0001001;
  localparam logic [6:0] G_N6 = 7'b0000010, G_N5 = 7'b0010010;

  note_display_ctrl #(.NUM_DIGITS(3), .STABLE_COUNT(4), .BLINK_HALF(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .note_valid (note_valid),
    .note_code  (note_code),
    .tune_err   (tune_err),
    .hex_out    (hex_out),
    .shown_code (shown_code),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // One valid sample captured on the next rising edge; returns 1 time unit after it
  task automatic send(input logic [3:0] code, input logic [1:0] err);
    @(negedge clk);
    note_valid = 1'b1;
    note_code  = code;
    tune_err   = err;
    @(posedge clk);
    #1;
    note_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (shown_code !== 4'hF) begin errors++; $display("FAIL reset_shown got %h want f", shown_code); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (hex_out !== {G_BLANK, G_BLANK, G_DASH}) begin errors++; $display("FAIL reset_hex got %b want %b", hex_out, {G_BLANK, G_BLANK, G_DASH}); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_commit();
    repeat (3) send(4'd1, 2'b00);
    checks++; if (hex_out[6:0] !== G_DASH || locked !== 1'b0) begin errors++; $display("FAIL commit_early got d0=%b lk=%b want %b 0", hex_out[6:0], locked, G_DASH); end
    send(4'd1, 2'b00);
    checks++; if (locked !== 1'b1 || shown_code !== 4'd1) begin errors++; $display("FAIL commit_lock got lk=%b sc=%h want 1 1", locked, shown_code); end
    checks++; if (hex_out !== {G_N5, G_BLANK, G_A}) begin errors++; $display("FAIL commit_hex got %b want %b", hex_out, {G_N5, G_BLANK, G_A}); end
  endtask

  task automatic test_change();
    send(4'd2, 2'b00);
    checks++; if (locked !== 1'b0 || shown_code !== 4'd1 || hex_out[6:0] !== G_A) begin errors++; $display("FAIL change_first got lk=%b sc=%h d0=%b want 0 1 %b", locked, shown_code, hex_out[6:0], G_A); end
    send(4'd2, 2'b00);
    send(4'd1, 2'b00);
    send(4'd2, 2'b00);
    send(4'd2, 2'b00);
    send(4'd2, 2'b00);
    checks++; if (locked !== 1'b0 || shown_code !== 4'd1) begin errors++; $display("FAIL change_hold got lk=%b sc=%h want 0 1", locked, shown_code); end
    send(4'd2, 2'b00);
    checks++; if (locked !== 1'b1 || shown_code !== 4'd2 || hex_out[6:0] !== G_D) begin errors++; $display("FAIL change_commit got lk=%b sc=%h d0=%b want 1 2 %b", locked, shown_code, hex_out[6:0], G_D); end
  endtask

  task automatic test_invalid();
    repeat (4) send(4'd3, 2'b00);
    checks++; if (locked !== 1'b1 || hex_out[6:0] !== G_G) begin errors++; $display("FAIL inv_lock_g got lk=%b d0=%b want 1 %b", locked, hex_out[6:0], G_G); end
    send(4'd3, 2'b11);
    checks++; if (locked !== 1'b0 || shown_code !== 4'hF || hex_out[6:0] !== G_DASH) begin errors++; $display("FAIL inv_nosig got lk=%b sc=%h d0=%b want 0 f %b", locked, shown_code, hex_out[6:0], G_DASH); end
    send(4'd0, 2'b00);
    send(4'd0, 2'b00);
    send(4'd9, 2'b00);
    repeat (3) send(4'd0, 2'b00);
    checks++; if (locked !== 1'b0 || hex_out[6:0] !== G_DASH) begin errors++; $display("FAIL inv_code_restart got lk=%b d0=%b want 0 %b", locked, hex_out[6:0], G_DASH); end
    send(4'd7, 2'b00);
  endtask

  task automatic test_tune();
    repeat (4) send(4'd0, 2'b01);
    checks++; if (hex_out !== {G_N6, G_L, G_E}) begin errors++; $display("FAIL tune_flat got %b want %b", hex_out, {G_N6, G_L, G_E}); end
    send(4'd0, 2'b10);
    checks++; if (hex_out[13:7] !== G_H || locked !== 1'b1 || shown_code !== 4'd0) begin errors++; $display("FAIL tune_sharp got d1=%b lk=%b sc=%h want %b 1 0", hex_out[13:7], locked, shown_code, G_H); end
    send(4'd0, 2'b00);
    checks++; if (hex_out[13:7] !== G_BLANK) begin errors++; $display("FAIL tune_ok got d1=%b want %b", hex_out[13:7], G_BLANK); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (locked !== 1'b1 || shown_code !== 4'd0) begin errors++; $display("FAIL idle_hold got lk=%b sc=%h want 1 0", locked, shown_code); end
  endtask

  task automatic test_mid_reset();
    send(4'd7, 2'b00);
    repeat (3) send(4'd4, 2'b00);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (shown_code !== 4'hF || locked !== 1'b0 || hex_out !== {G_BLANK, G_BLANK, G_DASH}) begin errors++; $display("FAIL midreset got sc=%h lk=%b hex=%b", shown_code, locked, hex_out); end
    @(negedge clk);
    resetn = 1'b1;
    send(4'd4, 2'b00);
    checks++; if (locked !== 1'b0 || hex_out[6:0] !== G_DASH) begin errors++; $display("FAIL midreset_discard got lk=%b d0=%b want 0 %b", locked, hex_out[6:0], G_DASH); end
  endtask

`ifdef NOTE_BLINK_EN
  task automatic test_blink();
    logic [6:0] want;
    send(4'd7, 2'b00);
    repeat (4) send(4'd1, 2'b01);
    checks++; if (hex_out[6:0] !== G_A) begin errors++; $display("FAIL blink_commit got %b want %b", hex_out[6:0], G_A); end
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      want = (j >= 3 && j <= 6) ? G_BLANK : G_A;
      checks++; if (hex_out[6:0] !== want) begin errors++; $display("FAIL blink_phase%0d got %b want %b", j, hex_out[6:0], want); end
    end
    send(4'd1, 2'b00);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      checks++; if (hex_out[6:0] !== G_A) begin errors++; $display("FAIL blink_steady%0d got %b want %b", j, hex_out[6:0], G_A); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_commit();
    test_change();
    test_invalid();
    test_tune();
    test_mid_reset();
`ifdef NOTE_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
